// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the stream_mux block.
package stream_mux_pkg;

  typedef enum logic {MUX_EMPTY, MUX_FULL} mux_state_t;
  typedef enum logic {MODE_FIXED, MODE_RR} mux_mode_t;

  // Channel-index width for an n-input mux.
  function automatic int sel_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/stream_mux_rr_arb.sv
// Rotating-priority picker: grants the first requesting channel after ptr,
// wrapping modulo N_IN. Purely combinational.
module stream_mux_rr_arb
  import stream_mux_pkg::*;
#(
  parameter int N_IN  = 8,
  parameter int SEL_W = sel_w(N_IN)
) (
  input  logic [N_IN-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             gnt_valid,
  output logic [SEL_W-1:0] gnt_idx
);

  logic [SEL_W:0]    shamt;
  logic [N_IN-1:0]   rot;
  int                idx;

  // Rotate requests so bit 0 is the channel just after ptr.
  always_comb begin
    shamt = {1'b0, ptr} + (SEL_W+1)'(1);
    rot   = N_IN'({req, req} >> shamt);
  end

  // First set bit of the rotated vector, mapped back to a channel index.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int j = 0; j < N_IN; j++) begin
      if (!gnt_valid && rot[j]) begin
        gnt_valid = 1'b1;
        idx       = int'(ptr) + 1 + j;
        if (idx >= N_IN) idx = idx - N_IN;
        gnt_idx   = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/stream_mux.sv
// N-input streaming mux with valid/ready on every port and a registered
// output beat tagged with its source channel. Define STREAM_MUX_RR_EN to
// add the rr_mode port and round-robin arbitration; without it the block
// is fixed-select only.
module stream_mux
  import stream_mux_pkg::*;
#(
  parameter int N_IN   = 8,
  parameter int DATA_W = 8,
  parameter int SEL_W  = sel_w(N_IN)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_IN*DATA_W-1:0] in_data,
  input  logic [N_IN-1:0]        in_valid,
  output logic [N_IN-1:0]        in_ready,
  input  logic [SEL_W-1:0]       sel,
`ifdef STREAM_MUX_RR_EN
  input  logic                   rr_mode,
`endif
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_ch,
  output logic                   out_valid,
  input  logic                   out_ready
);

  mux_state_t        state_q;
  logic [DATA_W-1:0] data_q;
  logic [SEL_W-1:0]  ch_q;
  mux_mode_t         mode;
  logic              free;
  logic              fix_vld;
  logic              chosen_vld;
  logic [SEL_W-1:0]  chosen_idx;
  logic              accept;
  logic [DATA_W-1:0] pick_data;

`ifdef STREAM_MUX_RR_EN
  logic [SEL_W-1:0]  ptr_q;
  logic [SEL_W-1:0]  ptr_d;
  logic              arb_vld;
  logic [SEL_W-1:0]  arb_idx;

  stream_mux_rr_arb #(
    .N_IN  (N_IN),
    .SEL_W (SEL_W)
  ) u_arb (
    .req       (in_valid),
    .ptr       (ptr_q),
    .gnt_valid (arb_vld),
    .gnt_idx   (arb_idx)
  );

  assign mode = rr_mode ? MODE_RR : MODE_FIXED;
`else
  assign mode = MODE_FIXED;
`endif

  // Pick the candidate channel; an out-of-range select chooses nothing.
  always_comb begin
    fix_vld = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      if (int'(sel) == i) fix_vld = 1'b1;
    end
    chosen_vld = fix_vld;
    chosen_idx = sel;
    if (mode == MODE_RR) begin
`ifdef STREAM_MUX_RR_EN
      chosen_vld = arb_vld;
      chosen_idx = arb_idx;
`else
      chosen_vld = 1'b0;
`endif
    end
  end

  // Handshake: only the chosen channel sees ready, and only when the output
  // register can take a beat this cycle. Ready is forced low during reset.
  always_comb begin
    free      = (state_q == MUX_EMPTY) || out_ready;
    in_ready  = '0;
    pick_data = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (int'(chosen_idx) == i) begin
        in_ready[i] = rst_n && free && chosen_vld;
        pick_data   = in_data[i*DATA_W +: DATA_W];
      end
    end
    accept = |(in_valid & in_ready);
  end

  // Output register FSM: load on accept, drain when consumed without reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MUX_EMPTY;
      data_q  <= '0;
      ch_q    <= '0;
    end else begin
      case (state_q)
        MUX_EMPTY: begin
          if (accept) begin
            state_q <= MUX_FULL;
            data_q  <= pick_data;
            ch_q    <= chosen_idx;
          end
        end
        MUX_FULL: begin
          if (accept) begin
            data_q <= pick_data;
            ch_q   <= chosen_idx;
          end else if (out_ready) begin
            state_q <= MUX_EMPTY;
          end
        end
        default: state_q <= MUX_EMPTY;
      endcase
    end
  end

`ifdef STREAM_MUX_RR_EN
  // Pointer advances only on round-robin grants; fixed-mode beats leave it.
  always_comb begin
    ptr_d = ptr_q;
    if (accept && (mode == MODE_RR)) ptr_d = chosen_idx;
  end

  // Pointer register; reset value gives channel 0 first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= SEL_W'(N_IN - 1);
    else        ptr_q <= ptr_d;
  end
`endif

  assign out_valid = (state_q == MUX_FULL);
  assign out_data  = data_q;
  assign out_ch    = ch_q;

endmodule

// File: tb/tb_stream_mux.sv
// Self-checking bench for stream_mux (N_IN=6 so out-of-range selects exist).
// Round-robin sequences run only when STREAM_MUX_RR_EN is defined.
module tb_stream_mux;

  localparam int N  = 6;
  localparam int W  = 8;
  localparam int SW = 3;

  logic           clk;
  logic           rst_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [SW-1:0]  sel;
  logic           rr_mode_tb;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_ch;
  logic           out_valid;
  logic           out_ready;

  stream_mux #(.N_IN(N), .DATA_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
`ifdef STREAM_MUX_RR_EN
    .rr_mode   (rr_mode_tb),
`endif
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [SW-1:0] sel;
    logic [N-1:0]  vld;
    logic [W-1:0]  seed;
    logic          ordy;
    logic [N-1:0]  exp_rdy;
    logic          exp_vld;
  } vec_t;

  typedef struct {
    logic [W-1:0]  data;
    logic [SW-1:0] ch;
  } beat_t;

  beat_t sb[$];
  beat_t held;
  vec_t  tbl[13];
  int    n_chk;
  int    n_fail;

  // Channel i carries seed ^ {i,i}.
  function automatic logic [W-1:0] chan_val(input logic [W-1:0] seed, input int i);
    logic [3:0] n;
    n = 4'(i);
    return seed ^ {n, n};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic apply(input logic [SW-1:0] s, input logic [N-1:0] v, input logic rrm,
                       input logic [W-1:0] seed, input logic ordy,
                       input logic [N-1:0] exp_rdy, input logic exp_vld, input string nm);
    logic [N-1:0] acc;
    int           ch;
    beat_t        b;
    @(negedge clk);
    sel        = s;
    in_valid   = v;
    rr_mode_tb = rrm;
    out_ready  = ordy;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = chan_val(seed, i);
    acc = exp_rdy & v;
    ch  = -1;
    for (int i = 0; i < N; i++) if (acc[i]) ch = i;
    if (ch >= 0) begin
      b.data = chan_val(seed, ch);
      b.ch   = SW'(ch);
      sb.push_back(b);
    end
    #1;
    check({nm, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
    if (ch >= 0) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s.scoreboard: got empty queue, expected a beat", nm);
      end else begin
        held = sb.pop_front();
        check({nm, ".out_valid"}, 32'(out_valid), 32'd1);
        check({nm, ".out_data"},  32'(out_data),  32'(held.data));
        check({nm, ".out_ch"},    32'(out_ch),    32'(held.ch));
      end
    end else if (exp_vld) begin
      check({nm, ".hold_valid"}, 32'(out_valid), 32'd1);
      check({nm, ".hold_data"},  32'(out_data),  32'(held.data));
      check({nm, ".hold_ch"},    32'(out_ch),    32'(held.ch));
    end else begin
      check({nm, ".out_valid"}, 32'(out_valid), 32'd0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = '0;
    rst_n    = 1'b0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    held       = '{default: '0};
    rst_n      = 1'b0;
    in_valid   = '1;
    in_data    = '1;
    sel        = '0;
    rr_mode_tb = 1'b0;
    out_ready  = 1'b1;

    //           sel    valid      seed   ordy  exp_rdy    exp_vld
    tbl[0]  = '{3'd3, 6'b001000, 8'h96, 1'b1, 6'b001000, 1'b1}; // ch3 = 0xA5
    tbl[1]  = '{3'd2, 6'b000100, 8'h33, 1'b1, 6'b000100, 1'b1}; // ch2 = 0x11
    tbl[2]  = '{3'd5, 6'b111111, 8'h55, 1'b0, 6'b000000, 1'b1}; // stall, sel moves
    tbl[3]  = '{3'd5, 6'b100000, 8'h66, 1'b0, 6'b000000, 1'b1};
    tbl[4]  = '{3'd5, 6'b100000, 8'h77, 1'b1, 6'b100000, 1'b1};
    tbl[5]  = '{3'd7, 6'b111111, 8'hC3, 1'b1, 6'b000000, 1'b0}; // sel out of range
    tbl[6]  = '{3'd6, 6'b111111, 8'hC3, 1'b1, 6'b000000, 1'b0};
    tbl[7]  = '{3'd1, 6'b000000, 8'h4B, 1'b1, 6'b000010, 1'b0}; // ready w/o valid
    tbl[8]  = '{3'd1, 6'b000010, 8'h4B, 1'b0, 6'b000010, 1'b1}; // ch1 = 0x5A
    tbl[9]  = '{3'd0, 6'b000001, 8'hE7, 1'b0, 6'b000000, 1'b1};
    tbl[10] = '{3'd0, 6'b000001, 8'hE7, 1'b1, 6'b000001, 1'b1}; // drain+reload
    tbl[11] = '{3'd4, 6'b010000, 8'h3C, 1'b1, 6'b010000, 1'b1};
    tbl[12] = '{3'd4, 6'b000000, 8'h3C, 1'b1, 6'b010000, 1'b0};

    // Reset state, with every channel presenting valid data.
    #3;
    check("rst.in_ready",  32'(in_ready),  32'd0);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.out_data",  32'(out_data),  32'd0);
    check("rst.out_ch",    32'(out_ch),    32'd0);
    @(posedge clk);
    #1;
    check("rst.in_ready_clk", 32'(in_ready), 32'd0);
    @(negedge clk);
    in_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 13; k++) begin
      apply(tbl[k].sel, tbl[k].vld, 1'b0, tbl[k].seed, tbl[k].ordy,
            tbl[k].exp_rdy, tbl[k].exp_vld, $sformatf("vec%0d", k));
    end

    // Reset while FULL with 0x3C held: cleared without waiting for a clock.
    apply(3'd4, 6'b010000, 1'b0, 8'h78, 1'b0, 6'b010000, 1'b1, "full3c");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async.out_valid", 32'(out_valid), 32'd0);
    check("async.out_data",  32'(out_data),  32'd0);
    check("async.out_ch",    32'(out_ch),    32'd0);
    check("async.in_ready",  32'(in_ready),  32'd0);
    sb.delete();
    @(negedge clk);
    in_valid = '0;
    rst_n    = 1'b1;

`ifdef STREAM_MUX_RR_EN
    // First grant after reset goes to the lowest valid channel.
    apply(3'd0, 6'b011100, 1'b1, 8'h40, 1'b1, 6'b000100, 1'b1, "rr_first");

    // Two requesters at the ends of the ring alternate, starting at ch0.
    do_reset();
    apply(3'd0, 6'b100001, 1'b1, 8'h12, 1'b1, 6'b000001, 1'b1, "rr_ends0");
    apply(3'd0, 6'b100001, 1'b1, 8'h34, 1'b1, 6'b100000, 1'b1, "rr_ends1");
    apply(3'd0, 6'b100001, 1'b1, 8'h56, 1'b1, 6'b000001, 1'b1, "rr_ends2");

    // All valid from reset: 0,1,...,5,0 with no bubbles.
    do_reset();
    for (int k = 0; k <= N; k++) begin
      apply(3'd0, 6'b111111, 1'b1, 8'(8'h80 + k), 1'b1, N'(1 << (k % N)), 1'b1,
            $sformatf("rr_all%0d", k));
    end

    // Stall in RR mode, then a fixed-mode beat, then RR resumes after ptr.
    apply(3'd0, 6'b111111, 1'b1, 8'h9A, 1'b0, 6'b000000, 1'b1, "rr_stall");
    apply(3'd2, 6'b111111, 1'b0, 8'hA1, 1'b1, 6'b000100, 1'b1, "rr_fixsw");
    apply(3'd0, 6'b111111, 1'b1, 8'hB2, 1'b1, 6'b000010, 1'b1, "rr_resume");
    apply(3'd0, 6'b000000, 1'b1, 8'hC3, 1'b1, 6'b000000, 1'b0, "rr_idle");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
